// File: rtl/amo_exec_unit_pkg.sv
// Shared definitions for the AMO execute unit.
// Holds the RISC-V AMO funct5 codes, the store length encodings, the FSM
// state encoding and the latched-operation payload. No ports.
package amo_exec_unit_pkg;

  localparam int unsigned F5_W   = 5;
  localparam int unsigned WLEN_W = 2;

  // RISC-V AMO funct5 codes
  localparam logic [F5_W-1:0] F5_ADD  = 5'b00000;
  localparam logic [F5_W-1:0] F5_SWAP = 5'b00001;
  localparam logic [F5_W-1:0] F5_LR   = 5'b00010;
  localparam logic [F5_W-1:0] F5_SC   = 5'b00011;
  localparam logic [F5_W-1:0] F5_XOR  = 5'b00100;
  localparam logic [F5_W-1:0] F5_OR   = 5'b01000;
  localparam logic [F5_W-1:0] F5_AND  = 5'b01100;
  localparam logic [F5_W-1:0] F5_MIN  = 5'b10000;
  localparam logic [F5_W-1:0] F5_MAX  = 5'b10100;
  localparam logic [F5_W-1:0] F5_MINU = 5'b11000;
  localparam logic [F5_W-1:0] F5_MAXU = 5'b11100;

  // Store length encodings
  localparam logic [WLEN_W-1:0] WLEN_WORD  = 2'b10;
  localparam logic [WLEN_W-1:0] WLEN_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Operation fields latched at issue
  typedef struct packed {
    logic [F5_W-1:0] funct5;
    logic            is_word;
  } amo_op_t;

  function automatic logic [WLEN_W-1:0] wlen_of(input logic is_word);
    return is_word ? WLEN_WORD : WLEN_DWORD;
  endfunction

endpackage

// File: rtl/amo_exec_unit_if.sv
// Bundle of the AMO issue, load-return, store-request and rd-return signals.
// master: upstream sequencer / memory / WB side (drives issue, rdata, wreq_ready).
// slave : the execute unit (drives store request, rd return and busy).
interface amo_exec_unit_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned AWIDTH = 32
);
  // Issue
  logic              start;
  logic [4:0]        funct5;
  logic              is_word;
  logic [AWIDTH-1:0] addr;
  logic [XLEN-1:0]   rs2;
  logic              sc_fail;
  logic              cancel;
  // Load return
  logic              rdata_valid;
  logic [XLEN-1:0]   rdata;
  // Store port
  logic              wreq_valid;
  logic              wreq_ready;
  logic [AWIDTH-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic [1:0]        wlen;
  // WB
  logic              rd_valid;
  logic [XLEN-1:0]   rd_data;
  logic              busy;

  modport master (
    output start, funct5, is_word, addr, rs2, sc_fail, cancel,
    output rdata_valid, rdata, wreq_ready,
    input  wreq_valid, waddr, wdata, wlen, rd_valid, rd_data, busy
  );

  modport slave (
    input  start, funct5, is_word, addr, rs2, sc_fail, cancel,
    input  rdata_valid, rdata, wreq_ready,
    output wreq_valid, waddr, wdata, wlen, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/amo_exec_unit_alu.sv
// Combinational AMO result f(old, rs2, funct5, is_word).
// Ports: old_i (memory value), rs2_i (operand), funct5_i, is_word_i,
//        result_c_o (store data; upper 32 bits zero for word ops).
module amo_exec_unit_alu
  import amo_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [F5_W-1:0] funct5_i,
  input  logic            is_word_i,
  output logic [XLEN-1:0] result_c_o
);

  logic            word;
  logic [XLEN-1:0] a_s, b_s, a_u, b_u, res;
  logic            s_lt, u_lt;

  // Word ops: sign-extend for signed compare, zero-extend for unsigned;
  // the low 32 bits of any result are then identical to a 32-bit datapath.
  always_comb begin
    word = (XLEN == 32) || is_word_i;
    a_s  = old_i;
    b_s  = rs2_i;
    a_u  = old_i;
    b_u  = rs2_i;
    if (word) begin
      a_s = XLEN'($signed(old_i[31:0]));
      b_s = XLEN'($signed(rs2_i[31:0]));
      a_u = XLEN'(old_i[31:0]);
      b_u = XLEN'(rs2_i[31:0]);
    end
    s_lt = $signed(a_s) < $signed(b_s);
    u_lt = a_u < b_u;

    case (funct5_i)
      F5_ADD:  res = a_u + b_u;
      F5_SWAP: res = b_u;
      F5_XOR:  res = a_u ^ b_u;
      F5_OR:   res = a_u | b_u;
      F5_AND:  res = a_u & b_u;
      F5_MIN:  res = s_lt ? a_u : b_u;
      F5_MAX:  res = s_lt ? b_u : a_u;
      F5_MINU: res = u_lt ? a_u : b_u;
      F5_MAXU: res = u_lt ? b_u : a_u;
      default: res = b_u;
    endcase

    result_c_o = word ? (res & XLEN'(32'hFFFF_FFFF)) : res;
  end

endmodule

// File: rtl/amo_exec_unit.sv
// AMO execute unit: captures the load return, computes the AMO result,
// issues one write-back store and returns the rd value.
// Ports: clk, rstn (synchronous, active-low), bus (amo_exec_unit_if.slave):
//   issue (start/funct5/is_word/addr/rs2/sc_fail/cancel), load return
//   (rdata_valid/rdata), store (wreq_*/waddr/wdata/wlen), rd_valid/rd_data, busy.
module amo_exec_unit
  import amo_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned AWIDTH = 32
) (
  input  logic           clk,
  input  logic           rstn,
  amo_exec_unit_if.slave bus
);

  state_e              state_q, state_d;
  amo_op_t             op_q, op_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;
  logic [XLEN-1:0]     rd_pend_q, rd_pend_d;
  logic                wreq_valid_q, wreq_valid_d;
  logic [AWIDTH-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [WLEN_W-1:0]   wlen_q, wlen_d;
  logic                rd_valid_q, rd_valid_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic                busy_q, busy_d;

  logic                start_word_c;
  logic                word_c;
  logic [XLEN-1:0]     old_c;
  logic [XLEN-1:0]     alu_res_c;

  // Word handling is forced on a 32-bit datapath
  assign start_word_c = (XLEN == 32) || bus.is_word;
  assign word_c       = (XLEN == 32) || op_q.is_word;
  assign old_c        = word_c ? XLEN'($signed(bus.rdata[31:0])) : bus.rdata;

  amo_exec_unit_alu #(.XLEN(XLEN)) u_amo_alu (
    .old_i      (old_c),
    .rs2_i      (rs2_q),
    .funct5_i   (op_q.funct5),
    .is_word_i  (word_c),
    .result_c_o (alu_res_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rs2_d        = rs2_q;
    rd_pend_d    = rd_pend_q;
    wreq_valid_d = wreq_valid_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wlen_d       = wlen_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = '{funct5: bus.funct5, is_word: bus.is_word};
          rs2_d   = bus.rs2;
          waddr_d = bus.addr;
          wlen_d  = wlen_of(start_word_c);
          if (bus.funct5 == F5_SC) begin
            if (bus.sc_fail) begin
              state_d    = ST_RESP;
              rd_valid_d = 1'b1;
              rd_data_d  = XLEN'(1);
            end else begin
              state_d      = ST_WRITE;
              wreq_valid_d = 1'b1;
              wdata_d      = start_word_c ? XLEN'(bus.rs2[31:0]) : bus.rs2;
              rd_pend_d    = '0;
            end
          end else begin
            state_d = ST_READ;
          end
        end
      end

      // cancel has priority over a same-cycle load return
      ST_READ: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (bus.rdata_valid) begin
          rd_pend_d = old_c;
          if (op_q.funct5 == F5_LR) begin
            state_d    = ST_RESP;
            rd_valid_d = 1'b1;
            rd_data_d  = old_c;
          end else begin
            state_d      = ST_WRITE;
            wreq_valid_d = 1'b1;
            wdata_d      = alu_res_c;
          end
        end
      end

      // Committed: cancel no longer has any effect
      ST_WRITE: begin
        if (bus.wreq_ready) begin
          state_d      = ST_RESP;
          wreq_valid_d = 1'b0;
          rd_valid_d   = 1'b1;
          rd_data_d    = rd_pend_q;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and holding registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      rs2_q        <= '0;
      rd_pend_q    <= '0;
      wreq_valid_q <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wlen_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rs2_q        <= rs2_d;
      rd_pend_q    <= rd_pend_d;
      wreq_valid_q <= wreq_valid_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wlen_q       <= wlen_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.wreq_valid = wreq_valid_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.wlen       = wlen_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.busy       = busy_q;

endmodule
